// File: rtl/if_pipe_controller_pkg.sv
// Shared definitions for the fetch-stage / IF-ID control sequencer:
// PC mux encodings, sequencer states and register-index width.
package if_pipe_controller_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] PCSRC_NEXT   = 2'd0;
  localparam logic [1:0] PCSRC_START  = 2'd1;
  localparam logic [1:0] PCSRC_BRANCH = 2'd2;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_FREEZE = 2'd3
  } state_e;

endpackage

// File: rtl/if_pipe_controller_if.sv
// Bundle between the fetch/decode datapath (master) and the pipe controller (slave).
interface if_pipe_controller_if;
  import if_pipe_controller_pkg::*;

  logic             mem_busy;
  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             if_id_uses_rt;
  logic             branch_taken;

  logic             PCWrite;
  logic             hzdetect;
  logic [1:0]       pc_src;
  logic             flush;
  logic             freeze;

  modport master (
    output mem_busy, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt, branch_taken,
    input  PCWrite, hzdetect, pc_src, flush, freeze
  );

  modport slave (
    input  mem_busy, id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt, branch_taken,
    output PCWrite, hzdetect, pc_src, flush, freeze
  );

endinterface

// File: rtl/if_pipe_controller_sat_counter.sv
// Saturating up-counter; a clear wins over a same-cycle increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/if_pipe_controller.sv
// Fetch-stage and IF/ID control: boot sequencing, load-use stalls, branch
// flushes and memory-wait freezes, plus saturating stall/flush counters.
module if_pipe_controller
  import if_pipe_controller_pkg::*;
#(
  parameter int BOOT_CYCLES    = 2,
  parameter int STALL_CYCLES   = 1,
  parameter int FREEZE_TIMEOUT = 64,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  if_pipe_controller_if.slave  bus,
  input  logic                 perf_clr,
  output logic                 boot_done,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int BOOT_W  = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int FRZ_W   = $clog2(FREEZE_TIMEOUT + 1);
  localparam logic [BOOT_W-1:0]  BOOT_LAST   = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [STALL_W-1:0] STALL_FIRST = STALL_W'(STALL_CYCLES - 1);
  localparam logic [FRZ_W-1:0]   FRZ_LIMIT   = FRZ_W'(FREEZE_TIMEOUT);

  state_e             state_q, state_d;
  logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [STALL_W-1:0] stall_rem_q, stall_rem_d;
  logic [FRZ_W-1:0]   freeze_cnt_q, freeze_cnt_d;
  logic               boot_done_q, boot_done_d;
  logic               timeout_err_q, timeout_err_d;

  logic       hazard;
  logic       pc_write, hz_det, flush_o, freeze_o;
  logic [1:0] pc_src_o;
  logic [1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_val [2];

  assign hazard = bus.id_ex_mem_read && (bus.id_ex_rt != '0) &&
                  ((bus.id_ex_rt == bus.if_id_rs) ||
                   (bus.if_id_uses_rt && (bus.id_ex_rt == bus.if_id_rt)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= '0;
      stall_rem_q   <= '0;
      freeze_cnt_q  <= '0;
      boot_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      stall_rem_q   <= stall_rem_d;
      freeze_cnt_q  <= freeze_cnt_d;
      boot_done_q   <= boot_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The freeze counter tracks consecutive mem_busy cycles, including the
  // cycle that first enters FREEZE; any non-busy cycle clears it.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    stall_rem_d   = stall_rem_q;
    freeze_cnt_d  = '0;
    boot_done_d   = boot_done_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d     = ST_RUN;
          boot_done_d = 1'b1;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      ST_STALL: begin
        if (bus.mem_busy) begin
          state_d      = ST_FREEZE;
          stall_rem_d  = '0;
          freeze_cnt_d = FRZ_W'(1);
        end else begin
          stall_rem_d = stall_rem_q - STALL_W'(1);
          if (stall_rem_q == STALL_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        if (bus.mem_busy) begin
          state_d      = ST_FREEZE;
          freeze_cnt_d = (freeze_cnt_q == FRZ_LIMIT) ? freeze_cnt_q : freeze_cnt_q + FRZ_W'(1);
        end else if (hazard && (STALL_CYCLES > 1)) begin
          state_d     = ST_STALL;
          stall_rem_d = STALL_FIRST;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
    if (freeze_cnt_d == FRZ_LIMIT) begin
      timeout_err_d = 1'b1;
    end
  end

  // FREEZE with mem_busy low falls through to the normal RUN decode.
  always_comb begin
    pc_write   = 1'b0;
    pc_src_o   = PCSRC_NEXT;
    flush_o    = 1'b0;
    freeze_o   = 1'b0;
    hz_det     = 1'b0;
    cnt_inc[1] = 1'b0;
    if (!rst) begin
      pc_src_o = PCSRC_START;
      flush_o  = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_write = 1'b1;
          pc_src_o = PCSRC_START;
          flush_o  = 1'b1;
        end
        ST_STALL: begin
          freeze_o = 1'b1;
          hz_det   = !bus.mem_busy;
        end
        default: begin
          if (bus.mem_busy) begin
            freeze_o = 1'b1;
          end else if (hazard) begin
            freeze_o = 1'b1;
            hz_det   = 1'b1;
          end else if (bus.branch_taken) begin
            pc_write   = 1'b1;
            pc_src_o   = PCSRC_BRANCH;
            flush_o    = 1'b1;
            cnt_inc[1] = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
      endcase
    end
    cnt_inc[0] = hz_det;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    sat_counter #(.WIDTH(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[gi]),
      .clr   (perf_clr),
      .count (cnt_val[gi])
    );
  end

  assign bus.PCWrite  = pc_write;
  assign bus.hzdetect = hz_det;
  assign bus.pc_src   = pc_src_o;
  assign bus.flush    = flush_o;
  assign bus.freeze   = freeze_o;
  assign boot_done    = boot_done_q;
  assign timeout_err  = timeout_err_q;
  assign stall_count  = cnt_val[0];
  assign flush_count  = cnt_val[1];

endmodule

// File: tb/tb_if_pipe_controller.sv
// Scoreboard bench: the driver pushes expected per-cycle outputs from a
// behavioural model; a negedge monitor pops and compares them.
module tb_if_pipe_controller;

  localparam int BOOT   = 2;
  localparam int STALL  = 3;
  localparam int FT     = 64;
  localparam int CW     = 8;
  localparam int CMAX   = (1 << CW) - 1;

  typedef struct packed {
    logic          pcwrite;
    logic          hzdetect;
    logic [1:0]    pc_src;
    logic          flush;
    logic          freeze;
    logic          boot_done;
    logic          timeout_err;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic perf_clr = 1'b0;
  logic boot_done, timeout_err;
  logic [CW-1:0] stall_count, flush_count;

  if_pipe_controller_if bus_if ();

  if_pipe_controller #(
    .BOOT_CYCLES(BOOT), .STALL_CYCLES(STALL), .FREEZE_TIMEOUT(FT), .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .perf_clr    (perf_clr),
    .boot_done   (boot_done),
    .timeout_err (timeout_err),
    .stall_count (stall_count),
    .flush_count (flush_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: remaining boot/stall cycles and a run of busy cycles.
  int m_boot_left = BOOT, m_stall_left = 0, m_busy_run = 0;
  int m_stall_cnt = 0, m_flush_cnt = 0;
  bit m_boot_done = 0, m_timeout = 0;

  task automatic model_step(output exp_t e);
    bit hz;
    e = '0;
    if (!rst) begin
      m_boot_left = BOOT; m_stall_left = 0; m_busy_run = 0;
      m_stall_cnt = 0; m_flush_cnt = 0; m_boot_done = 0; m_timeout = 0;
      e.pc_src = 2'd1;
      e.flush  = 1'b1;
      return;
    end
    e.boot_done   = m_boot_done;
    e.timeout_err = m_timeout;
    e.stall_count = CW'(m_stall_cnt);
    e.flush_count = CW'(m_flush_cnt);
    hz = bus_if.id_ex_mem_read && (bus_if.id_ex_rt != 0) &&
         ((bus_if.id_ex_rt == bus_if.if_id_rs) ||
          (bus_if.if_id_uses_rt && (bus_if.id_ex_rt == bus_if.if_id_rt)));
    if (m_boot_left > 0) begin
      e.pcwrite = 1; e.pc_src = 2'd1; e.flush = 1;
      m_boot_left--;
      if (m_boot_left == 0) m_boot_done = 1;
    end else if (bus_if.mem_busy) begin
      e.freeze = 1;
      m_stall_left = 0;
      m_busy_run++;
      if (m_busy_run >= FT) m_timeout = 1;
    end else begin
      m_busy_run = 0;
      if (m_stall_left > 0) begin
        e.freeze = 1; e.hzdetect = 1;
        m_stall_left--;
      end else if (hz) begin
        e.freeze = 1; e.hzdetect = 1;
        m_stall_left = STALL - 1;
      end else if (bus_if.branch_taken) begin
        e.pcwrite = 1; e.pc_src = 2'd2; e.flush = 1;
        if (!perf_clr && m_flush_cnt < CMAX) m_flush_cnt++;
      end else begin
        e.pcwrite = 1;
      end
    end
    if (perf_clr) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else if (e.hzdetect && m_stall_cnt < CMAX) begin
      m_stall_cnt++;
    end
  endtask

  task automatic drive(bit r, bit mb, bit mr, logic [4:0] ert, logic [4:0] rs,
                       logic [4:0] rt, bit ur, bit br, bit pc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    bus_if.mem_busy       = mb;
    bus_if.id_ex_mem_read = mr;
    bus_if.id_ex_rt       = ert;
    bus_if.if_id_rs       = rs;
    bus_if.if_id_rt       = rt;
    bus_if.if_id_uses_rt  = ur;
    bus_if.branch_taken   = br;
    perf_clr = pc;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic chk(string name, int act, int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL cyc=%0d %s: got=%0d want=%0d", cyc, name, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk("PCWrite",     int'(bus_if.PCWrite),  int'(e.pcwrite));
        chk("hzdetect",    int'(bus_if.hzdetect), int'(e.hzdetect));
        chk("pc_src",      int'(bus_if.pc_src),   int'(e.pc_src));
        chk("flush",       int'(bus_if.flush),    int'(e.flush));
        chk("freeze",      int'(bus_if.freeze),   int'(e.freeze));
        chk("boot_done",   int'(boot_done),       int'(e.boot_done));
        chk("timeout_err", int'(timeout_err),     int'(e.timeout_err));
        chk("stall_count", int'(stall_count),     int'(e.stall_count));
        chk("flush_count", int'(flush_count),     int'(e.flush_count));
        if (cyc % 500 == 0)
          $display("cycle %0d pc_src=%0d st=%0d fl=%0d", cyc, bus_if.pc_src, stall_count, flush_count);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    int burst = 0;
    bit mb;
    bus_if.mem_busy = 0; bus_if.id_ex_mem_read = 0; bus_if.id_ex_rt = 0;
    bus_if.if_id_rs = 0; bus_if.if_id_rt = 0; bus_if.if_id_uses_rt = 0;
    bus_if.branch_taken = 0;
    // reset and boot
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(4);
    // load-use on rs, rt=0 no-hazard, load-use on rt
    drive(1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    idle(4);
    drive(1, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    drive(1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
    drive(1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
    idle(3);
    // hazard with branch, then branch alone
    drive(1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0);
    idle(2);
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    idle(1);
    // mem_busy pre-empting a stall, hazard still present after release
    drive(1, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    repeat (3) drive(1, 1, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    drive(1, 0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0);
    idle(4);
    // timeout at 64 busy cycles, sticky until reset
    repeat (66) drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(3);
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(4);
    // flush counter saturation and perf_clr priority
    repeat (CMAX + 5) drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
    drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    idle(2);
    // randomized traffic
    repeat (3000) begin
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(60, 70);
      if (burst > 0) begin
        mb = 1;
        burst--;
      end else begin
        mb = ($urandom_range(0, 5) == 0);
      end
      drive($urandom_range(0, 299) != 0, mb, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    chk("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_pipe_controller.md
Name: if_pipe_controller

Overview:
Control sequencer for the fetch stage and the IF/ID boundary of the 32-bit pipeline.
- Produces PCWrite, hzdetect, PC mux select, IF2ID flush and IF2ID freeze.
- Inputs are the load-use hazard compare, branch resolution in ID and the data-memory wait.
- Runs the post-reset boot sequence and keeps saturating stall/flush performance counters.
- Sits beside the fetch stage; all of its outputs drive that stage directly.

Parameters:
BOOT_CYCLES, 2, cycles the PC is forced to Start_Address after reset release (>=1)
STALL_CYCLES, 1, load-use bubble length in cycles (>=1)
FREEZE_TIMEOUT, 64, consecutive mem_busy cycles before timeout_err sets
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
mem_busy  in  1  data memory not ready; whole pipeline must hold
id_ex_mem_read  in  1  instruction in EX is a load
id_ex_rt  in  5  load destination register
if_id_rs  in  5  rs of instruction in ID
if_id_rt  in  5  rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt
branch_taken  in  1  branch resolved taken in ID this cycle
perf_clr  in  1  synchronous clear of both counters
PCWrite  out  1  PC register load enable
hzdetect  out  1  insert bubble into ID/EX
pc_src  out  2  PC mux select: 0 Next_Address, 1 Start_Address, 2 Branch_Address; 3 never driven
flush  out  1  IF2ID clear
freeze  out  1  IF2ID hold
boot_done  out  1  high once boot sequence complete
timeout_err  out  1  sticky memory-wait timeout flag
stall_count  out  CNT_W  load-use stall cycles, saturating
flush_count  out  CNT_W  branch flushes, saturating

Behaviour:
- States: BOOT, RUN, STALL, FREEZE. The state register is the only source of sequencing; outputs are decoded combinationally from the state and the current inputs.
- Reset (rst=0, asynchronous):
  - state=BOOT, boot counter=0, stall counter=0, freeze counter=0, counters=0, timeout_err=0, boot_done=0.
  - Outputs held at: PCWrite=0, pc_src=1, flush=1, freeze=0, hzdetect=0.
- BOOT:
  - Outputs: PCWrite=1, pc_src=1, flush=1, freeze=0, hzdetect=0. All hazard inputs are ignored.
  - After BOOT_CYCLES cycles, go to RUN and set boot_done=1; it stays 1 until reset.
- hazard = id_ex_mem_read & (id_ex_rt!=0) & ((id_ex_rt==if_id_rs) | (if_id_uses_rt & id_ex_rt==if_id_rt)).
- RUN priority, highest first:
  1. mem_busy: PCWrite=0, freeze=1, flush=0, hzdetect=0 in the same cycle; go to FREEZE.
  2. hazard: PCWrite=0, freeze=1, hzdetect=1 in the same cycle. If STALL_CYCLES>1, go to STALL with remaining=STALL_CYCLES-1. branch_taken is ignored this cycle because the branch operands are stale.
  3. branch_taken: pc_src=2, PCWrite=1, flush=1 in the same cycle; flush_count increments.
  4. Otherwise: pc_src=0, PCWrite=1, flush/freeze/hzdetect=0.
- STALL:
  - Outputs as in hazard cycle; remaining decrements each cycle; go to RUN after the cycle in which remaining reaches 1.
  - mem_busy pre-empts the stall: go to FREEZE and discard the remaining stall count. The hazard is re-evaluated in RUN afterwards.
- FREEZE:
  - Outputs: PCWrite=0, freeze=1, hzdetect=0, flush=0; pc_src holds 0.
  - Go to RUN in the first cycle mem_busy=0; normal RUN decode applies in that cycle.
  - The freeze counter increments per FREEZE cycle and clears on exit. Reaching FREEZE_TIMEOUT sets timeout_err, which is sticky until reset.
  - The branch source keeps branch_taken/address stable while frozen; no pending latch exists.
- stall_count increments on every cycle hzdetect=1.
- Both counters saturate at all-ones. perf_clr takes priority over a same-cycle increment.
- pc_src is never 3. flush and freeze are never both 1 outside BOOT/reset (BOOT drives freeze=0).
- Reset asserted mid-STALL or mid-FREEZE returns to BOOT immediately and clears all counters and flags.

Decomposition:
- Shared package: pc_src encodings (PCSRC_NEXT=0, PCSRC_START=1, PCSRC_BRANCH=2), state encoding, register-index width (5).
- One sub-module, sat_counter (width parameter, inc, clr), instantiated twice for stall_count and flush_count.
- Hazard compare stays inline.

Test Plan:
1. Reset release, BOOT_CYCLES=2 -> pc_src=1 and flush=1 for 2 cycles, then boot_done=1 and pc_src=0, PCWrite=1.
2. id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 -> hzdetect=1, freeze=1, PCWrite=0 for exactly STALL_CYCLES cycles; stall_count=1. Same with rt=0 -> no stall.
3. branch_taken=1 and hazard in the same cycle -> stall only, flush=0. Branch next cycle -> pc_src=2, flush=1, flush_count=1.
4. mem_busy high 3 cycles during a STALL_CYCLES=3 stall -> freeze=1, PCWrite=0 throughout. Release -> RUN, hazard re-evaluated.
5. mem_busy high 64 cycles -> timeout_err=1 at cycle 64. It stays 1 after mem_busy drops and clears only on rst=0.
6. Force 65535 flushes, one more branch -> flush_count stays 65535. perf_clr with a simultaneous branch -> count 0.
